// File: rtl/pc_stack_unit_pkg.sv
// Shared widths, operation encoding and strobe priority for the pc stack unit.
// Pure declarations, no latency; no handshake involved.
// Circular-stack option is selected by PC_STACK_CIRC_EN in the users of this package.
package pc_pkg;

    localparam int ADDR_W_DEF      = 11;
    localparam int REL_W_DEF       = 10;
    localparam int STACK_DEPTH_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INCR,
        OP_PRELOAD,
        OP_JSR,
        OP_RET
    } pc_op_t;

    // One operation per cycle: preload > jsr > ret > incr.
    function automatic pc_op_t pick_op(input logic incr, input logic preload,
                                       input logic jsr, input logic ret);
        if (preload)   return OP_PRELOAD;
        else if (jsr)  return OP_JSR;
        else if (ret)  return OP_RET;
        else if (incr) return OP_INCR;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Decoder-to-pc-unit bus: command strobes in, pc and stack status out.
// Wires only, no latency; strobes are level-sampled, no backpressure.
// Widths track the pc_stack_unit parameters (PC_STACK_CIRC_EN does not affect them).
interface pc_stack_unit_if
    import pc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int REL_W       = REL_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic              incr;
    logic              preload;
    logic [ADDR_W-1:0] addr;
    logic              jsr;
    logic [REL_W-1:0]  relative_addr;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_prev;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output incr, preload, addr, jsr, relative_addr, ret,
        input  pc, pc_prev, stack_level, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  incr, preload, addr, jsr, relative_addr, ret,
        output pc, pc_prev, stack_level, stack_full, stack_empty, stack_err
    );

endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO with level/full/empty; circular overwrite when PC_STACK_CIRC_EN is defined.
// Push/pop take effect on the next clock edge; top_dat is combinational from the stored entries.
// No backpressure: pushes while full are dropped (or overwrite the oldest entry), pops while empty ignored.
module pc_ret_stack #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_dat,
    output logic [W-1:0]             top_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign pop_ok = pop && !empty;
`ifdef PC_STACK_CIRC_EN
    // When full, wr_ptr already points at the oldest entry, so a push overwrites it.
    assign push_ok = push;
`else
    assign push_ok = push && !full;
`endif

    assign top_dat = mem[wr_ptr - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            level  <= '0;
        end else if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full)
                level <= level + LVL_W'(1);
        end else if (pop_ok) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            level  <= level - LVL_W'(1);
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with relative jsr, multi-level return stack and sticky stack error (option PC_STACK_CIRC_EN).
// Latency 1: strobes sampled on the rising clk edge, registered pc/pc_prev/err visible the next cycle.
// No backpressure: one operation per cycle by priority, suppressed jsr/ret only raise stack_err.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int REL_W       = REL_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pc_stack_unit_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    pc_op_t            op;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_prev_q;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] rel_ext;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top_dat;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              ovf;
    logic              unf;
    logic              err_q;

    assign op       = pick_op(bus.incr, bus.preload, bus.jsr, bus.ret);
    assign rel_ext  = ADDR_W'($signed(bus.relative_addr));
    assign ret_addr = pc_q + ADDR_W'(1);

`ifdef PC_STACK_CIRC_EN
    assign push = (op == OP_JSR);
    assign ovf  = 1'b0;
`else
    assign push = (op == OP_JSR) && !full;
    assign ovf  = (op == OP_JSR) && full;
`endif
    assign pop = (op == OP_RET) && !empty;
    assign unf = (op == OP_RET) && empty;

    always_comb begin
        next_pc = pc_q;
        case (op)
            OP_PRELOAD: next_pc = bus.addr;
            OP_JSR:     if (push) next_pc = pc_q + rel_ext;
            OP_RET:     if (pop)  next_pc = top_dat;
            OP_INCR:    next_pc = pc_q + ADDR_W'(1);
            default:    next_pc = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            pc_prev_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (next_pc != pc_q) begin
                pc_prev_q <= pc_q;
                pc_q      <= next_pc;
            end
            if (ovf || unf)
                err_q <= 1'b1;
        end
    end

    pc_ret_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (ret_addr),
        .top_dat  (top_dat),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    assign bus.pc          = pc_q;
    assign bus.pc_prev     = pc_prev_q;
    assign bus.stack_level = level;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised successor program counter for the TP2 processor core.
- Adds a multi-level return-address stack: nested subroutines, no single saved register.
- Adds signed relative jumps and synchronous clocked operation.
- Adds stack status and error flags.
- Sits between the instruction decoder (command strobes) and program memory (pc address).

Parameters:
ADDR_W, 11, width of pc, pc_prev, addr and stack entries
REL_W, 10, width of relative_addr (two's-complement offset)
STACK_DEPTH, 4, number of return-address entries (>=2, power of two)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
incr  input  1  advance pc by one this cycle
preload  input  1  absolute load of pc from addr
addr  input  ADDR_W  absolute target
jsr  input  1  jump to subroutine: push return address, pc += sign-extended relative_addr
relative_addr  input  REL_W  signed offset for jsr
ret  input  1  return: pop stack into pc
pc  output  ADDR_W  current program counter (registered)
pc_prev  output  ADDR_W  pc value before the most recent change
stack_level  output  $clog2(STACK_DEPTH)+1  occupied entries
stack_full  output  1  stack_level == STACK_DEPTH
stack_empty  output  1  stack_level == 0
stack_err  output  1  sticky over/underflow flag

Behaviour:
- Reset (async assert, released synchronously by the clock domain): pc=0, pc_prev=0, stack_level=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- All updates occur on the rising clk edge. Results are visible the cycle after the strobe (latency 1).
- Strobes are level-sampled each cycle. Holding a strobe for N cycles gives N operations.
- Priority when strobes coincide: preload > jsr > ret > incr. Exactly one operation per cycle. Lower-priority strobes that cycle are ignored, with no side effects.
- preload: pc <= addr. Stack untouched.
- jsr:
  - push (pc + 1) mod 2^ADDR_W.
  - pc <= (pc + sext(relative_addr)) mod 2^ADDR_W.
  - The offset is relative to the jsr's own pc.
- ret: pc <= top entry; stack_level decrements.
- incr: pc <= pc + 1, wrapping from 2^ADDR_W-1 to 0.
- No strobe: pc holds.
- pc_prev <= old pc whenever pc changes value. Otherwise pc_prev holds.
- jsr while stack_full (macro undefined):
  - Whole jsr suppressed: pc holds, no push.
  - stack_err <= 1.
- ret while stack_empty:
  - pc holds, level stays 0.
  - stack_err <= 1.
- stack_err clears only on rst.
- preload does not alter the stack. A program may abandon frames; this is legal.
- Reset mid-operation aborts any strobe in that cycle. The stack is emptied logically.

Optional Feature:
PC_STACK_CIRC_EN
- Defined:
  - Stack is circular. jsr when full overwrites the oldest entry and proceeds normally.
  - stack_level saturates at STACK_DEPTH.
  - stack_err is set only by underflow.
- Undefined: overflow behaviour as in Behaviour (suppress jsr, set stack_err).

Decomposition:
- Package pc_pkg:
  - ADDR_W/REL_W/STACK_DEPTH defaults.
  - Typedef pc_op_t enum {OP_HOLD, OP_INCR, OP_PRELOAD, OP_JSR, OP_RET} produced by the priority encoder.
  - Typedef addr_t.
- Sub-module pc_ret_stack:
  - Parametrised LIFO with push/pop, full/empty, level.
  - Circular mode selected by the macro.
  - Top level keeps the priority encoder, pc/pc_prev registers and offset arithmetic.

Test Plan:
- Reset then 5 cycles of incr -> pc=5, pc_prev=4; assert rst mid-run -> pc=0, pc_prev=0, stack_empty=1 immediately (async).
- preload addr=0x100 with incr and ret also high -> pc=0x100, stack_level unchanged; next incr -> pc=0x101, pc_prev=0x100.
- At pc=0x010: jsr rel=+0x020 -> pc=0x030, level=1; at pc=0x030: jsr rel=-3 (0x3FD) -> pc=0x02D, level=2; ret -> pc=0x031; ret -> pc=0x011, stack_empty=1.
- Four nested jsr (DEPTH=4) -> stack_full=1; fifth jsr at pc=0x050 -> pc=0x050, stack_err=1 (macro off); with PC_STACK_CIRC_EN -> jump taken, err=0, four rets return the four newest addresses.
- ret at reset -> pc=0, stack_err=1, level=0; later incr still advances, stack_err stays 1.
- preload addr=0x7FF, incr -> pc=0x000, pc_prev=0x7FF; jsr at 0x7FF rel=+2 -> pc=0x001, pushed 0x000.
